// File: rtl/t_ff.sv
// Bank of toggle flip-flops with synchronous reset, parallel load and clock enable.
// Each bit is an independent lane; Qn is the combinational inverse of Q.

module t_ff_lane (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic t,
    input  logic load,
    input  logic d,
    input  logic rst_val,
    output logic q,
    output logic tog
);
    // Priority: rst > load > ce-gated toggle > hold
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= rst_val;
            tog <= 1'b0;
        end else if (load) begin
            q   <= d;
            tog <= 1'b0;
        end else if (ce) begin
            q   <= q ^ t;
            tog <= t;
        end else begin
            tog <= 1'b0;
        end
    end
endmodule

module t_ff #(
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] T,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [WIDTH-1:0] toggled
);
    localparam logic [WIDTH-1:0] RV = RESET_VAL;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        t_ff_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .ce      (ce),
            .t       (T[i]),
            .load    (load),
            .d       (d[i]),
            .rst_val (RV[i]),
            .q       (Q[i]),
            .tog     (toggled[i])
        );
    end

    assign Qn = ~Q;
endmodule

// File: tb/tb_t_ff.sv
// Bench for t_ff: a 1-bit and a 4-bit instance driven together, checked against
// a priority-rule reference model with directed steps followed by random traffic.

module tb_t_ff;
    localparam logic [3:0] RV4 = 4'b1001;

    logic       clk = 1'b0;
    logic       rst, ce, load;
    logic [3:0] t_in, d_in;
    logic [3:0] q4, qn4, tog4;
    logic [0:0] q1, qn1, tog1;

    int checks = 0;
    int fails  = 0;

    logic [3:0] m4, mt4;
    logic       m1, mt1;

    always #5 clk = ~clk;

    t_ff #(.WIDTH(4), .RESET_VAL(RV4)) u_wide (
        .clk(clk), .rst(rst), .ce(ce), .T(t_in), .load(load), .d(d_in),
        .Q(q4), .Qn(qn4), .toggled(tog4)
    );

    t_ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_narrow (
        .clk(clk), .rst(rst), .ce(ce), .T(t_in[0:0]), .load(load), .d(d_in[0:0]),
        .Q(q1), .Qn(qn1), .toggled(tog1)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock edge: drive on negedge, model the edge, check shortly after posedge.
    task automatic step(input logic r, input logic c, input logic ld,
                        input logic [3:0] tt, input logic [3:0] dd);
        @(negedge clk);
        rst = r; ce = c; load = ld; t_in = tt; d_in = dd;
        @(posedge clk);
        #1;
        if (r) begin
            m4 = RV4;      mt4 = '0;  m1 = 1'b0;     mt1 = 1'b0;
        end else if (ld) begin
            m4 = dd;       mt4 = '0;  m1 = dd[0];    mt1 = 1'b0;
        end else if (c) begin
            m4 = m4 ^ tt;  mt4 = tt;  m1 = m1 ^ tt[0]; mt1 = tt[0];
        end else begin
            mt4 = '0;      mt1 = 1'b0;
        end
        check("q4",   q4,   m4);
        check("qn4",  qn4,  ~m4);
        check("tog4", tog4, mt4);
        check("q1",   {3'b0, q1},   {3'b0, m1});
        check("qn1",  {3'b0, qn1},  {3'b0, ~m1});
        check("tog1", {3'b0, tog1}, {3'b0, mt1});
    endtask

    initial begin
        logic [4:0] tseq;
        logic [4:0] qexp;
        rst = 1'b1; ce = 1'b0; load = 1'b0; t_in = '0; d_in = '0;
        m4 = 'x; mt4 = 'x; m1 = 1'bx; mt1 = 1'bx;

        // Reset state
        step(1, 0, 0, 4'h0, 4'h0);
        check("rst_q1_const",  {3'b0, q1},  4'b0000);
        check("rst_qn1_const", {3'b0, qn1}, 4'b0001);
        check("rst_q4_const",  q4, RV4);

        // 1-bit T sequence 0,1,1,0,1 -> Q 0,1,0,0,1
        tseq = 5'b10110;  // bit k is T at edge k
        qexp = 5'b10010;
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, {3'b000, tseq[k]}, 4'h0);
            check("seq_q1_const", {3'b0, q1}, {3'b0, qexp[k]});
        end

        // Width 4 from zero, T=1010 twice
        step(0, 0, 1, 4'h0, 4'h0);
        step(0, 1, 0, 4'b1010, 4'h0);
        check("w4_e1_const", q4, 4'b1010);
        step(0, 1, 0, 4'b1010, 4'h0);
        check("w4_e2_const", q4, 4'b0000);
        check("w4_tog_const", tog4, 4'b1010);

        // Load overrides toggle; reset overrides load
        step(0, 1, 1, 4'b1111, 4'b0110);
        check("load_const", q4, 4'b0110);
        step(1, 1, 1, 4'b1111, 4'b0110);
        check("rst_load_const", q4, RV4);

        // Clock enable low freezes state
        for (int k = 0; k < 3; k++) step(0, 0, 0, 4'b1111, 4'h0);
        check("ce0_const", q4, RV4);

        // Reset mid-stream while toggling, then resume
        for (int k = 0; k < 3; k++) step(0, 1, 0, 4'b1111, 4'h0);
        step(1, 1, 0, 4'b1111, 4'h0);
        check("mid_rst_const", q4, RV4);
        step(0, 1, 0, 4'b1111, 4'h0);
        check("resume_const", q4, ~RV4);

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), 4'($urandom), 4'($urandom));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
